gray_coder: RTL and testbench

Parameterised, registered binary/Gray code converter. It converts a WIDTH-bit word binary->Gray or Gray->binary, selected per sample. Output is registered with one-cycle latency and a valid qualifier. Used wherever counters or positions cross into or out of Gray-coded domains, such as FIFO pointers and encoders.

---
 rtl/gray_pkg.sv | 33 +++
 rtl/gray_conv_comb.sv | 38 +++
 rtl/gray_coder.sv | 76 +++++++
 tb/tb_gray_coder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the binary/Gray converter: default width, mode encoding
// and word-level conversion helpers operating on a maximum-width word.
package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 4;
  localparam int GRAY_MAX_WIDTH     = 32;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] word);
    return word ^ (word >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits of a narrow word do not disturb the result.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] word);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b = '0;
    b[GRAY_MAX_WIDTH-1] = word[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ word[i];
    end
    return b;
  endfunction

  function automatic logic one_bit_diff(input logic [GRAY_MAX_WIDTH-1:0] a,
                                        input logic [GRAY_MAX_WIDTH-1:0] b);
    logic [GRAY_MAX_WIDTH-1:0] x;
    x = a ^ b;
    return (x != '0) && ((x & (x - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/gray_conv_comb.sv
// Combinational binary<->Gray conversion of one word, selected by mode.
// With GRAY_ADJ_FLAG_EN it also exposes the Gray-domain form of the sample.
module gray_conv_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
`ifdef GRAY_ADJ_FLAG_EN
  output logic [WIDTH-1:0] gray_word,
`endif
  output logic [WIDTH-1:0] conv_word
);

  logic [GRAY_MAX_WIDTH-1:0] w_ext;
  logic [WIDTH-1:0]          w_b2g;
  logic [WIDTH-1:0]          w_g2b;

  assign w_ext = GRAY_MAX_WIDTH'(data_in);
  assign w_b2g = WIDTH'(bin2gray(w_ext));
  assign w_g2b = WIDTH'(gray2bin(w_ext));

  always_comb begin
    conv_word = w_b2g;
    if (mode == MODE_G2B) begin
      conv_word = w_g2b;
    end else begin
      conv_word = w_b2g;
    end
  end

`ifdef GRAY_ADJ_FLAG_EN
  // In G2B mode the input already is the Gray-domain word.
  assign gray_word = (mode == MODE_G2B) ? data_in : w_b2g;
`endif

endmodule

// File: rtl/gray_coder.sv
// Registered binary/Gray converter with one-cycle latency and valid qualifier.
// Optional macro GRAY_ADJ_FLAG_EN adds adj_flag (single-bit Gray step vs. previous sample).
module gray_coder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
`ifdef GRAY_ADJ_FLAG_EN
  output logic             adj_flag,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] w_conv;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

`ifdef GRAY_ADJ_FLAG_EN
  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] r_hist;
  logic             r_hist_valid;
  logic             r_adj;
`endif

  gray_conv_comb #(.WIDTH(WIDTH)) u_conv (
    .data_in   (data_in),
    .mode      (mode),
`ifdef GRAY_ADJ_FLAG_EN
    .gray_word (w_gray),
`endif
    .conv_word (w_conv)
  );

  // Output register: data_out holds its last value while no sample is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_conv;
      end
    end
  end

`ifdef GRAY_ADJ_FLAG_EN
  // History of the last accepted Gray-domain word and the adjacency flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist       <= '0;
      r_hist_valid <= 1'b0;
      r_adj        <= 1'b0;
    end else if (in_valid) begin
      r_adj        <= r_hist_valid &&
                      one_bit_diff(GRAY_MAX_WIDTH'(w_gray), GRAY_MAX_WIDTH'(r_hist));
      r_hist       <= w_gray;
      r_hist_valid <= 1'b1;
    end else begin
      r_adj        <= 1'b0;
    end
  end

  assign adj_flag = r_adj;
`endif

  assign out_valid = r_valid;
  assign data_out  = r_data;

endmodule

// File: tb/tb_gray_coder.sv
// Scoreboard bench for gray_coder: a 4-bit and an 8-bit instance share valid/mode.
// Reference Gray codes come from the reflected-table construction, not from XOR formulas.
module tb_gray_coder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       mode;
  logic [3:0] din4;
  logic [7:0] din8;
  logic       ov4, ov8;
  logic [3:0] dout4;
  logic [7:0] dout8;
`ifdef GRAY_ADJ_FLAG_EN
  logic       adj4, adj8;
`endif

  always #5 clk = ~clk;

  gray_coder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .data_in(din4),
`ifdef GRAY_ADJ_FLAG_EN
    .adj_flag(adj4),
`endif
    .out_valid(ov4), .data_out(dout4)
  );

  gray_coder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .data_in(din8),
`ifdef GRAY_ADJ_FLAG_EN
    .adj_flag(adj8),
`endif
    .out_valid(ov8), .data_out(dout8)
  );

  typedef struct {
    logic       v;
    logic [3:0] d4;
    logic [7:0] d8;
    logic       a4;
    logic       a8;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int         gt[256];
  logic [3:0] last4;
  logic [7:0] last8;
  logic       hv4, hv8;
  logic [7:0] hist4, hist8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_b2g(input int b);
    return gt[b];
  endfunction

  function automatic int model_g2b(input int g, input int w);
    for (int i = 0; i < (1 << w); i++) begin
      if (gt[i] == g) return i;
    end
    return -1;
  endfunction

  function automatic int diff_bits(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      if (a[i] != b[i]) n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    last4 = '0; last8 = '0;
    hv4 = 1'b0; hv8 = 1'b0;
    hist4 = '0; hist8 = '0;
  endtask

  // Drive one cycle with explicit expected converted words.
  task automatic issue_dir(input logic v, input logic m, input logic [3:0] x4, input logic [3:0] k4,
                           input logic [7:0] x8, input logic [7:0] k8);
    exp_t e;
    logic [7:0] g4, g8;
    @(negedge clk);
    in_valid = v; mode = m; din4 = x4; din8 = x8;
    e.v = v; e.a4 = 1'b0; e.a8 = 1'b0;
    if (v) begin
      last4 = k4; last8 = k8;
      g4 = m ? {4'd0, x4} : {4'd0, k4};
      g8 = m ? x8 : k8;
      e.a4 = hv4 && (diff_bits(g4, hist4) == 1);
      e.a8 = hv8 && (diff_bits(g8, hist8) == 1);
      hist4 = g4; hist8 = g8; hv4 = 1'b1; hv8 = 1'b1;
    end
    e.d4 = last4; e.d8 = last8;
    q.push_back(e);
  endtask

  task automatic issue_rand(input logic v, input logic m, input logic [3:0] x4, input logic [7:0] x8);
    logic [3:0] k4;
    logic [7:0] k8;
    k4 = m ? 4'(model_g2b(int'(x4), 4)) : 4'(model_b2g(int'(x4)));
    k8 = m ? 8'(model_g2b(int'(x8), 8)) : 8'(model_b2g(int'(x8)));
    issue_dir(v, m, x4, k4, x8, k8);
  endtask

  // Monitor: pops one expectation per issued cycle, just after the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid4", 32'(ov4), 32'(e.v));
        chk("out_valid8", 32'(ov8), 32'(e.v));
        chk("data_out4", 32'(dout4), 32'(e.d4));
        chk("data_out8", 32'(dout8), 32'(e.d8));
`ifdef GRAY_ADJ_FLAG_EN
        chk("adj_flag4", 32'(adj4), 32'(e.a4));
        chk("adj_flag8", 32'(adj8), 32'(e.a8));
`endif
      end
    end
  end

  initial begin
    logic [3:0] sweep [16];
    logic [3:0] g2b_in [4];
    logic [3:0] g2b_out [4];
    logic [3:0] adj_in [4];
    logic [3:0] adj_out [4];
    sweep   = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    g2b_in  = '{4'b1000, 4'b1011, 4'b0110, 4'b0000};
    g2b_out = '{4'b1111, 4'b1101, 4'b0100, 4'b0000};
    adj_in  = '{4'b1101, 4'b1100, 4'b1110, 4'b1110};
    adj_out = '{4'b1011, 4'b1010, 4'b1001, 4'b1001};

    // Reflected Gray table: prefix 0 to the previous list, then 1 to it reversed.
    gt[0] = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gt[(1 << k) + i] = gt[(1 << k) - 1 - i] + (1 << k);
      end
    end

    model_reset();
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; din4 = '0; din8 = '0;
    #2;
    chk("reset_valid4", 32'(ov4), 32'd0);
    chk("reset_data4", 32'(dout4), 32'd0);
    chk("reset_data8", 32'(dout8), 32'd0);
`ifdef GRAY_ADJ_FLAG_EN
    chk("reset_adj4", 32'(adj4), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int b = 0; b < 16; b++) begin
      if (b == 15) issue_dir(1'b1, 1'b0, 4'(b), sweep[b], 8'hFF, 8'h80);
      else         issue_rand(1'b1, 1'b0, 4'(b), 8'($urandom_range(0, 255)));
      if (b != 15) q[q.size()-1].d4 = sweep[b];
    end

    issue_dir(1'b1, 1'b1, 8'd0 + g2b_in[0], g2b_out[0], 8'h80, 8'hFF);
    for (int i = 1; i < 4; i++) begin
      issue_rand(1'b1, 1'b1, g2b_in[i], 8'($urandom_range(0, 255)));
      q[q.size()-1].d4 = g2b_out[i];
    end

    issue_rand(1'b1, 1'b0, 4'b0101, 8'h5A);
    q[q.size()-1].d4 = 4'b0111;
    issue_rand(1'b0, 1'b1, 4'b1111, 8'h00);
    issue_rand(1'b0, 1'b0, 4'b0000, 8'hFF);
    issue_rand(1'b1, 1'b1, 4'b0111, 8'h33);
    q[q.size()-1].d4 = 4'b0101;

    for (int n = 0; n < 300; n++) begin
      issue_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    // Mid-stream reset with nonzero outputs, checked between clock edges.
    issue_rand(1'b1, 1'b0, 4'b1111, 8'hF0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid4", 32'(ov4), 32'd0);
    chk("midrst_data4", 32'(dout4), 32'd0);
    chk("midrst_valid8", 32'(ov8), 32'd0);
    chk("midrst_data8", 32'(dout8), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      issue_rand(1'b1, 1'b0, adj_in[i], 8'($urandom_range(0, 255)));
      q[q.size()-1].d4 = adj_out[i];
    end
    for (int i = 0; i < 3; i++) issue_rand(1'b0, 1'b0, 4'd0, 8'd0);

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
